// File: rtl/entry_pkg.sv
// rtl/entry_pkg.sv - shared encodings and digit helpers for the preset entry block
package entry_pkg;

    localparam int DIGIT_W = 4;
    localparam int VALUE_W = 7;

    typedef enum logic [1:0] {
        ST_EDIT_UNITS = 2'd0,
        ST_EDIT_TENS  = 2'd1,
        ST_COMMIT     = 2'd2
    } state_t;

    function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
        return (d >= DIGIT_W'(9)) ? '0 : d + DIGIT_W'(1);
    endfunction

    function automatic logic [DIGIT_W-1:0] digit_dec(input logic [DIGIT_W-1:0] d);
        return (d == '0) ? DIGIT_W'(9) : d - DIGIT_W'(1);
    endfunction

    // Digits never exceed 9, so 9*10+9 = 99 always fits in VALUE_W bits.
    function automatic logic [VALUE_W-1:0] recombine(input logic [DIGIT_W-1:0] tens,
                                                     input logic [DIGIT_W-1:0] units);
        return VALUE_W'(tens) * VALUE_W'(10) + VALUE_W'(units);
    endfunction

endpackage

// File: rtl/button_edge_conditioner.sv
// rtl/button_edge_conditioner.sv - synchronise, tick-debounce and edge-detect one raw button
module button_edge_conditioner #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (tick) begin
                // Any sample equal to the accepted level restarts the run count.
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    pulse <= sync2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bcd_preset_entry.sv
// rtl/bcd_preset_entry.sv - two-digit decimal preset editor with committed binary value and load strobe
module bcd_preset_entry
    import entry_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int MAX_VALUE      = 99
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               btn_inc,
    input  logic               btn_dec,
    input  logic               btn_next,
    input  logic               btn_enter,
    output logic [DIGIT_W-1:0] digit_units,
    output logic [DIGIT_W-1:0] digit_tens,
    output logic               field_sel,
    output logic [VALUE_W-1:0] value_out,
    output logic               value_valid
);

    localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(MAX_VALUE);

    logic ev_inc;
    logic ev_dec;
    logic ev_next;
    logic ev_enter;

    button_edge_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_inc (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn_inc), .pulse(ev_inc)
    );
    button_edge_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_dec (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn_dec), .pulse(ev_dec)
    );
    button_edge_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_next (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn_next), .pulse(ev_next)
    );
    button_edge_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_enter (
        .clk(clk), .rst(rst), .tick(tick), .btn(btn_enter), .pulse(ev_enter)
    );

    state_t             state;
    logic [VALUE_W-1:0] combined;

    assign combined = recombine(digit_tens, digit_units);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_EDIT_UNITS;
            digit_units <= '0;
            digit_tens  <= '0;
            field_sel   <= 1'b0;
            value_out   <= '0;
            value_valid <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            case (state)
                ST_EDIT_UNITS, ST_EDIT_TENS: begin
                    // Priority enter > next > inc/dec; losers are simply dropped.
                    if (ev_enter) begin
                        state       <= ST_COMMIT;
                        field_sel   <= 1'b0;
                        value_valid <= 1'b1;
                        value_out   <= (combined > MAX_V) ? MAX_V : combined;
                    end else if (ev_next) begin
                        if (state == ST_EDIT_UNITS) begin
                            state     <= ST_EDIT_TENS;
                            field_sel <= 1'b1;
                        end else begin
                            state     <= ST_EDIT_UNITS;
                            field_sel <= 1'b0;
                        end
                    end else if (ev_inc ^ ev_dec) begin
                        if (state == ST_EDIT_TENS) begin
                            digit_tens <= ev_inc ? digit_inc(digit_tens) : digit_dec(digit_tens);
                        end else begin
                            digit_units <= ev_inc ? digit_inc(digit_units) : digit_dec(digit_units);
                        end
                    end
                end
                ST_COMMIT: begin
                    state     <= ST_EDIT_UNITS;
                    field_sel <= 1'b0;
                end
                default: begin
                    state     <= ST_EDIT_UNITS;
                    field_sel <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_preset_entry.sv
// tb/tb_bcd_preset_entry.sv - self-checking bench for bcd_preset_entry against a digit-level model
module tb_bcd_preset_entry;

    localparam int DT = 4;
    localparam int HOLD = DT + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       btn_inc = 1'b0, btn_dec = 1'b0, btn_next = 1'b0, btn_enter = 1'b0;
    logic [3:0] units, tens, units50, tens50;
    logic       fsel, fsel50, vvalid, vvalid50;
    logic [6:0] vout, vout50;

    bcd_preset_entry #(.DEBOUNCE_TICKS(DT), .MAX_VALUE(99)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_next(btn_next), .btn_enter(btn_enter),
        .digit_units(units), .digit_tens(tens), .field_sel(fsel),
        .value_out(vout), .value_valid(vvalid)
    );

    bcd_preset_entry #(.DEBOUNCE_TICKS(DT), .MAX_VALUE(50)) dut50 (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_next(btn_next), .btn_enter(btn_enter),
        .digit_units(units50), .digit_tens(tens50), .field_sel(fsel50),
        .value_out(vout50), .value_valid(vvalid50)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vv_cnt = 0;
    logic [6:0] vout_at_valid = '0;
    logic       fsel_at_valid = 1'b0;

    int m_units = 0, m_tens = 0, m_sel = 0, m_vv = 0;
    int m_value = 0, m_value50 = 0;

    initial begin : tick_gen
        int tc;
        tc = 0;
        forever begin
            @(negedge clk);
            tc = (tc + 1) % 3;
            tick = (tc == 0);
        end
    end

    initial begin : valid_mon
        forever begin
            @(negedge clk);
            if (vvalid === 1'b1) begin
                vv_cnt++;
                vout_at_valid = vout;
                fsel_at_valid = fsel;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (got running, need finished)");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
    endtask

    // mask bits: 0 inc, 1 dec, 2 next, 3 enter
    task automatic press(input logic [3:0] m, input int hold);
        @(negedge clk);
        btn_inc = m[0]; btn_dec = m[1]; btn_next = m[2]; btn_enter = m[3];
        wait_ticks(hold);
        @(negedge clk);
        btn_inc = 0; btn_dec = 0; btn_next = 0; btn_enter = 0;
        wait_ticks(HOLD);
        @(negedge clk);
    endtask

    task automatic model_apply(input logic [3:0] m);
        if (m[3]) begin
            m_value   = (m_tens * 10 + m_units > 99) ? 99 : m_tens * 10 + m_units;
            m_value50 = (m_tens * 10 + m_units > 50) ? 50 : m_tens * 10 + m_units;
            m_vv++;
            m_sel = 0;
        end else if (m[2]) begin
            m_sel = 1 - m_sel;
        end else if (m[0] != m[1]) begin
            if (m_sel == 1) m_tens  = m[0] ? (m_tens + 1) % 10 : (m_tens + 9) % 10;
            else            m_units = m[0] ? (m_units + 1) % 10 : (m_units + 9) % 10;
        end
    endtask

    task automatic press_model(input logic [3:0] m);
        press(m, HOLD);
        model_apply(m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        m_units = 0; m_tens = 0; m_sel = 0; m_value = 0; m_value50 = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++; if (units !== 4'd0) begin errors++; $display("FAIL reset_units got %0d need 0", units); end
        checks++; if (tens !== 4'd0) begin errors++; $display("FAIL reset_tens got %0d need 0", tens); end
        checks++; if (fsel !== 1'b0) begin errors++; $display("FAIL reset_field_sel got %b need 0", fsel); end
        checks++; if (vout !== 7'd0) begin errors++; $display("FAIL reset_value_out got %0d need 0", vout); end
        checks++; if (vvalid !== 1'b0 || vv_cnt != 0) begin
            errors++; $display("FAIL reset_value_valid got %b/%0d pulses need 0/0", vvalid, vv_cnt);
        end
    endtask

    task automatic test_entry();
        do_reset();
        repeat (3) press_model(4'b0001);
        checks++; if (units !== 4'(m_units)) begin errors++; $display("FAIL inc3_units got %0d need %0d", units, m_units); end
        press_model(4'b1000);
        checks++; if (vv_cnt != m_vv) begin errors++; $display("FAIL enter3_pulses got %0d need %0d", vv_cnt, m_vv); end
        checks++; if (vout !== 7'(m_value) || m_value != 3) begin
            errors++; $display("FAIL enter3_value got %0d need %0d", vout, m_value);
        end
        do_reset();
        press_model(4'b0100);
        checks++; if (fsel !== 1'b1) begin errors++; $display("FAIL next_field_sel got %b need 1", fsel); end
        press_model(4'b0010);
        checks++; if (tens !== 4'(m_tens)) begin errors++; $display("FAIL tens_wrap got %0d need %0d", tens, m_tens); end
        press_model(4'b0100);
        repeat (5) press_model(4'b0001);
        press_model(4'b1000);
        checks++; if (vout !== 7'(m_value) || m_value != 95) begin
            errors++; $display("FAIL enter95_value got %0d need %0d", vout, m_value);
        end
        checks++; if (fsel_at_valid !== 1'b0 || fsel !== 1'b0) begin
            errors++; $display("FAIL enter95_field_sel got %b/%b need 0/0", fsel_at_valid, fsel);
        end
        checks++; if (vv_cnt != m_vv) begin errors++; $display("FAIL enter95_pulses got %0d need %0d", vv_cnt, m_vv); end
    endtask

    task automatic test_clamp();
        do_reset();
        press_model(4'b0100);
        repeat (7) press_model(4'b0001);
        press_model(4'b0100);
        repeat (3) press_model(4'b0001);
        press_model(4'b1000);
        checks++; if (vout50 !== 7'(m_value50)) begin errors++; $display("FAIL clamp50_value got %0d need %0d", vout50, m_value50); end
        checks++; if (vout !== 7'(m_value)) begin errors++; $display("FAIL clamp99_73_value got %0d need %0d", vout, m_value); end
        do_reset();
        press_model(4'b0010);
        press_model(4'b0100);
        press_model(4'b0010);
        press_model(4'b1000);
        checks++; if (vout !== 7'(m_value)) begin errors++; $display("FAIL max99_value got %0d need %0d", vout, m_value); end
        checks++; if (vout50 !== 7'(m_value50)) begin errors++; $display("FAIL max50_99_value got %0d need %0d", vout50, m_value50); end
        checks++; if (units !== 4'(m_units) || tens !== 4'(m_tens)) begin
            errors++; $display("FAIL digits_retained got %0d%0d need %0d%0d", tens, units, m_tens, m_units);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        @(negedge clk);
        btn_inc = 1;
        for (int i = 0; i < 10; i++) begin
            wait_ticks(1);
            @(negedge clk);
            btn_inc = ~btn_inc;
        end
        btn_inc = 1;
        wait_ticks(HOLD);
        @(negedge clk);
        btn_inc = 0;
        wait_ticks(HOLD);
        @(negedge clk);
        model_apply(4'b0001);
        checks++; if (units !== 4'(m_units)) begin errors++; $display("FAIL bounce_single_inc got %0d need %0d", units, m_units); end
        press(4'b0001, DT - 2);
        checks++; if (units !== 4'(m_units)) begin errors++; $display("FAIL short_press got %0d need %0d", units, m_units); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press_model(4'b0001);
        press_model(4'b0011);
        checks++; if (units !== 4'(m_units)) begin errors++; $display("FAIL inc_dec_same got %0d need %0d", units, m_units); end
        press_model(4'b0100);
        press_model(4'b1100);
        checks++; if (vv_cnt != m_vv) begin errors++; $display("FAIL enter_next_pulses got %0d need %0d", vv_cnt, m_vv); end
        checks++; if (fsel_at_valid !== 1'b0 || fsel !== 1'b0) begin
            errors++; $display("FAIL enter_next_field_sel got %b/%b need 0/0", fsel_at_valid, fsel);
        end
        checks++; if (vout !== 7'(m_value)) begin errors++; $display("FAIL enter_next_value got %0d need %0d", vout, m_value); end
    endtask

    task automatic test_reset_in_commit();
        int n;
        do_reset();
        press_model(4'b0001);
        press_model(4'b0001);
        @(negedge clk);
        btn_enter = 1;
        n = 0;
        while (vvalid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 200) begin errors++; $display("FAIL commit_timeout got no value_valid need pulse within 200 clk"); end
        model_apply(4'b1000);
        rst = 1;
        btn_enter = 0;
        @(negedge clk);
        rst = 0;
        checks++; if (vvalid !== 1'b0) begin errors++; $display("FAIL rst_commit_valid got %b need 0", vvalid); end
        checks++; if (vout !== 7'd0) begin errors++; $display("FAIL rst_commit_value got %0d need 0", vout); end
        m_units = 0; m_tens = 0; m_sel = 0;
        wait_ticks(HOLD);
        @(negedge clk);
        checks++; if (vv_cnt != m_vv || units !== 4'd0) begin
            errors++; $display("FAIL rst_commit_after got %0d pulses units %0d need %0d pulses units 0", vv_cnt, units, m_vv);
        end
    endtask

    task automatic test_random();
        logic [3:0] m;
        int op;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 3);
            m = 4'b0001 << op;
            if ($urandom_range(0, 4) == 0) begin
                press(m, DT - 2);
            end else begin
                press_model(m);
            end
            checks++; if (units !== 4'(m_units) || tens !== 4'(m_tens) || fsel !== 1'(m_sel)) begin
                errors++; $display("FAIL random_%0d_digits got %0d%0d sel %b need %0d%0d sel %0d",
                                   i, tens, units, fsel, m_tens, m_units, m_sel);
            end
            checks++; if (vv_cnt != m_vv || vout !== 7'(m_value)) begin
                errors++; $display("FAIL random_%0d_value got %0d pulses value %0d need %0d pulses value %0d",
                                   i, vv_cnt, vout, m_vv, m_value);
            end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_clamp();
        test_bounce();
        test_simultaneous();
        test_reset_in_commit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
